macc_core_scheduler: RTL and testbench

- Time-shares one hls_macc-style compute core (ap_start/ap_done/ap_idle/ap_ready handshake, 10 operand inputs, three outputs with ap_vld, plus ap_return) between N_REQ requesters.
- Grants requesters round-robin, latches the winner's operands, runs the core, and returns one tagged response per job.
- Includes a watchdog so a stuck core is reported rather than hanging the system.

---
 rtl/macc_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/macc_core_scheduler.sv | 177 +++++++++++++++++
 tb/tb_macc_core_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_sched_pkg.sv
// Shared definitions for the MACC core scheduler: FSM states, defaults and
// the layout of the response data word.
package macc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } sched_state_e;

    localparam int N_OPS_DEF  = 10;
    localparam int RSP_FIELDS = 4;

    // Word positions inside rsp_data = {ret, out3, out2, out1}
    localparam int RSP_OUT1 = 0;
    localparam int RSP_OUT2 = 1;
    localparam int RSP_OUT3 = 2;
    localparam int RSP_RET  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping around modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int   pos_s;
    logic take_s;

    // Scan upward from the pointer; the first request found wins
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        pos_s  = 0;
        take_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos_s     = int'(ptr) + i;
            pos_s     = (pos_s >= N) ? (pos_s - N) : pos_s;
            take_s    = en & ~any & req[pos_s];
            gnt[pos_s] = gnt[pos_s] | take_s;
            idx       = take_s ? IW'(pos_s) : idx;
            any       = any | take_s;
        end
    end

endmodule

// File: rtl/macc_core_scheduler.sv
// Time-shares one ap_ctrl_hs MACC core between N_REQ requesters: round-robin
// grant, operand latch, core run with watchdog, tagged response, and a drain
// phase that waits out a core that timed out.
module macc_core_scheduler
    import macc_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int N_OPS   = N_OPS_DEF,
    parameter int TMO_CYC = 64
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*N_OPS*DATA_W-1:0]     req_ops,
    output logic                              core_start,
    input  logic                              core_done,
    input  logic                              core_idle,
    input  logic                              core_ready,
    output logic [N_OPS*DATA_W-1:0]           core_ops,
    input  logic [3*DATA_W-1:0]               core_out,
    input  logic [2:0]                        core_out_vld,
    input  logic [DATA_W-1:0]                 core_ret,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [$clog2(N_REQ)-1:0]          rsp_id,
    output logic [RSP_FIELDS*DATA_W-1:0]      rsp_data,
    output logic                              rsp_err,
    output logic                              busy
);

    localparam int IW      = $clog2(N_REQ);
    localparam int SLICE_W = N_OPS * DATA_W;
    localparam int CNT_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    sched_state_e              state_r;
    logic [IW-1:0]             ptr_r;
    logic [IW-1:0]             job_id_r;
    logic [SLICE_W-1:0]        ops_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      tmo_r;

    logic [N_REQ-1:0]          gnt_s;
    logic [IW-1:0]             gidx_s;
    logic                      gany_s;
    logic [SLICE_W-1:0]        win_ops_s;
    logic [IW-1:0]             ptr_nxt_s;
    logic                      tmo_hit_s;
    logic                      vld_bad_s;
    logic [RSP_FIELDS*DATA_W-1:0] cap_data_s;

    // The core always sees the latched operands, so they cannot move mid-job
    assign core_ops = ops_r;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_r),
        .en  (state_r == IDLE),
        .gnt (gnt_s),
        .idx (gidx_s),
        .any (gany_s)
    );

    // Winner operand slice, next pointer, watchdog expiry and response packing
    always_comb begin
        win_ops_s = req_ops[int'(gidx_s)*SLICE_W +: SLICE_W];
        if (gidx_s == IW'(N_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gidx_s + IW'(1);
        end
        tmo_hit_s  = (cnt_r == TMO_LAST);
        vld_bad_s  = ~(&core_out_vld);
        cap_data_s = '0;
        cap_data_s[RSP_OUT1*DATA_W +: DATA_W] = core_out[0*DATA_W +: DATA_W];
        cap_data_s[RSP_OUT2*DATA_W +: DATA_W] = core_out[1*DATA_W +: DATA_W];
        cap_data_s[RSP_OUT3*DATA_W +: DATA_W] = core_out[2*DATA_W +: DATA_W];
        cap_data_s[RSP_RET*DATA_W  +: DATA_W] = core_ret;
    end

    // Scheduler FSM with registered handshake and response outputs
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            job_id_r   <= '0;
            ops_r      <= '0;
            cnt_r      <= '0;
            tmo_r      <= 1'b0;
            req_ready  <= '0;
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state_r)
                IDLE: begin
                    if (gany_s) begin
                        req_ready  <= gnt_s;
                        ops_r      <= win_ops_s;
                        ptr_r      <= ptr_nxt_s;
                        job_id_r   <= gidx_s;
                        cnt_r      <= '0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= START;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                START, WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Completion wins over the watchdog when both land together
                    if (core_done && (core_ready || state_r == WAIT)) begin
                        core_start <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= job_id_r;
                        rsp_data   <= cap_data_s;
                        rsp_err    <= vld_bad_s;
                        tmo_r      <= 1'b0;
                        state_r    <= RESP;
                    end else if (tmo_hit_s) begin
                        core_start <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= job_id_r;
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        tmo_r      <= 1'b1;
                        state_r    <= RESP;
                    end else if (state_r == START && core_ready) begin
                        core_start <= 1'b0;
                        state_r    <= WAIT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (tmo_r) begin
                            state_r <= DRAIN;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    // A timed-out core may still finish; its results are dropped
                    if (core_done || core_idle) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    rsp_valid  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macc_core_scheduler.sv
// Self-checking bench: core stub derives results from core_ops, a scoreboard
// queue holds the response expected for every grant.
module tb_macc_core_scheduler;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int N_OPS  = 10;
    localparam int TMO    = 8;
    localparam int IW     = 2;
    localparam int CW     = N_OPS * DATA_W;

    logic                          ap_clk = 1'b0;
    logic                          ap_rst;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ*N_OPS*DATA_W-1:0] req_ops;
    logic                          core_start;
    logic                          core_done;
    logic                          core_idle;
    logic                          core_ready;
    logic [CW-1:0]                 core_ops;
    logic [3*DATA_W-1:0]           core_out;
    logic [2:0]                    core_out_vld;
    logic [DATA_W-1:0]             core_ret;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [IW-1:0]                 rsp_id;
    logic [4*DATA_W-1:0]           rsp_data;
    logic                          rsp_err;
    logic                          busy;

    always #5 ap_clk = ~ap_clk;

    macc_core_scheduler #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .N_OPS(N_OPS), .TMO_CYC(TMO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
        .core_start(core_start), .core_done(core_done), .core_idle(core_idle),
        .core_ready(core_ready), .core_ops(core_ops), .core_out(core_out),
        .core_out_vld(core_out_vld), .core_ret(core_ret),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct {
        logic [IW-1:0]       id;
        logic [4*DATA_W-1:0] data;
        logic                err;
    } exp_t;

    exp_t         exp_q[$];
    int           gnt_log[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  ops_m [N_REQ][N_OPS];
    logic [31:0]  cur_ops [N_OPS];
    int           pending [N_REQ];
    int           phase = 0, st_cnt = 0, dn_cnt = 0;
    int           ready_dly = 1, done_dly = 4;
    bit           never_done = 1'b0, drain_release = 1'b0;
    logic [2:0]   vld_mask = 3'b111;
    int           cyc = 0, gnt_cyc = 0, rsp_first_cyc = -1, start_hi = 0, rsp_cnt = 0;
    logic [N_REQ-1:0]    last_gnt_vec = '0;
    logic [4*DATA_W-1:0] last_rsp_data = '0;

    task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        for (int r = 0; r < N_REQ; r++) begin
            req_valid[r] = (pending[r] > 0);
            for (int k = 0; k < N_OPS; k++)
                req_ops[(r*N_OPS+k)*DATA_W +: DATA_W] = ops_m[r][k];
        end
    endtask

    task automatic load_ops(input int r, input bit ramp);
        for (int k = 0; k < N_OPS; k++)
            ops_m[r][k] = ramp ? 32'(k + 1) : $urandom;
    endtask

    task automatic stub_done();
        core_done    = 1'b1;
        core_out     = {core_ops[2*32 +: 32] + 32'h30, core_ops[1*32 +: 32] + 32'h20,
                        core_ops[0*32 +: 32] + 32'h10};
        core_ret     = core_ops[3*32 +: 32] + 32'h40;
        core_out_vld = vld_mask;
    endtask

    // Core model, updated once per cycle on the falling edge
    task automatic stub_update();
        if (ap_rst) begin
            phase = 0; st_cnt = 0; core_ready = 1'b0; core_done = 1'b0;
            core_idle = 1'b1; core_out_vld = 3'b000;
        end else begin
            case (phase)
                0: begin
                    core_ready = 1'b0; core_done = 1'b0; core_idle = 1'b1;
                    if (core_start) begin
                        st_cnt++;
                        if (st_cnt == ready_dly) begin
                            core_ready = 1'b1; core_idle = 1'b0; st_cnt = 0; dn_cnt = 0;
                            if (done_dly == 0) begin stub_done(); phase = 2; end
                            else phase = 1;
                        end
                    end
                end
                1: begin
                    core_ready = 1'b0; core_idle = 1'b0; dn_cnt++;
                    if (!never_done && dn_cnt == done_dly) begin
                        stub_done(); phase = 2;
                    end else if (drain_release) begin
                        core_idle = 1'b1; drain_release = 1'b0; phase = 0;
                    end
                end
                default: begin
                    core_done = 1'b0; core_out_vld = 3'b000; core_idle = 1'b1; phase = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        bit hs; logic [IW-1:0] h_id; logic [4*DATA_W-1:0] h_data; logic h_err;
        exp_t e; int gid; logic [CW-1:0] ev;
        hs = rsp_valid && rsp_ready && !ap_rst;
        h_id = rsp_id; h_data = rsp_data; h_err = rsp_err;
        @(posedge ap_clk);
        if (hs) begin
            rsp_cnt++;
            last_rsp_data = h_data;
            if (exp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check_eq("rsp_id", h_id, e.id);
                check_eq("rsp_data", h_data, e.data);
                check_eq("rsp_err", h_err, e.err);
            end
        end
        @(negedge ap_clk);
        cyc++;
        if (req_ready != '0) begin
            check_eq("gnt_onehot", $onehot(req_ready), 1);
            gid = 0;
            for (int r = 0; r < N_REQ; r++) if (req_ready[r]) gid = r;
            check_eq("gnt_had_req", pending[gid] > 0, 1);
            gnt_log.push_back(gid);
            last_gnt_vec = req_ready; gnt_cyc = cyc; rsp_first_cyc = -1; start_hi = 0;
            for (int k = 0; k < N_OPS; k++) cur_ops[k] = ops_m[gid][k];
            e.id = IW'(gid);
            if (never_done) begin e.data = '0; e.err = 1'b1; end
            else begin
                e.data = {cur_ops[3] + 32'h40, cur_ops[2] + 32'h30, cur_ops[1] + 32'h20, cur_ops[0] + 32'h10};
                e.err  = (vld_mask != 3'b111);
            end
            exp_q.push_back(e);
            pending[gid]--;
            if (pending[gid] > 0) load_ops(gid, 1'b0);
            drive_req();
        end
        if (core_start) start_hi++;
        if (!ap_rst && (core_start || phase == 1)) begin
            ev = '0;
            for (int k = 0; k < N_OPS; k++) ev[k*32 +: 32] = cur_ops[k];
            check_eq("core_ops", core_ops, ev);
        end
        if (rsp_valid && rsp_first_cyc < 0) rsp_first_cyc = cyc;
        stub_update();
    endtask

    task automatic run_quiet(input int budget);
        bit ok; int pend;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            pend = 0;
            for (int r = 0; r < N_REQ; r++) pend += pending[r];
            if (pend == 0 && exp_q.size() == 0 && !busy && phase == 0) ok = 1'b1;
        end
        if (!ok) check_eq("quiet_budget", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, '0);
        check_eq({tag, "_core_start"}, core_start, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_id"}, rsp_id, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_rsp_err"}, rsp_err, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got sim time %0t expected finish earlier", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int exp_order[5];
        int base;
        logic [IW-1:0] s_id; logic [4*DATA_W-1:0] s_data; logic s_err;
        bit seen;

        ap_rst = 1'b1; req_valid = '0; req_ops = '0; rsp_ready = 1'b1;
        core_done = 1'b0; core_ready = 1'b0; core_idle = 1'b1;
        core_out = '0; core_out_vld = 3'b000; core_ret = '0;
        for (int r = 0; r < N_REQ; r++) begin pending[r] = 0; load_ops(r, 1'b0); end
        repeat (3) step();
        check_reset_outputs("reset");
        ap_rst = 1'b0;

        // Round robin with all requesters valid
        pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
        drive_req(); gnt_log.delete();
        run_quiet(400);
        exp_order = '{0, 1, 2, 3, 0};
        check_eq("rr_count", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) check_eq("rr_order", gnt_log[i], exp_order[i]);

        // Single job, requester 2, operands 1..10
        load_ops(2, 1'b1); pending[2] = 1; drive_req();
        run_quiet(100);
        check_eq("single_gnt", last_gnt_vec, 4'b0100);
        check_eq("single_data", last_rsp_data, {32'h44, 32'h33, 32'h22, 32'h11});

        // Backpressure on the response channel with another request waiting
        rsp_ready = 1'b0; pending[1] = 1; pending[3] = 1; load_ops(1, 1'b0); load_ops(3, 1'b0); drive_req();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin step(); seen = rsp_valid; end
        check_eq("bp_rsp_seen", seen, 1);
        s_id = rsp_id; s_data = rsp_data; s_err = rsp_err;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_id", rsp_id, s_id);
            check_eq("bp_data", rsp_data, s_data);
            check_eq("bp_err", rsp_err, s_err);
            check_eq("bp_no_gnt", req_ready, '0);
        end
        rsp_ready = 1'b1;
        run_quiet(200);

        // Delayed core_ready
        ready_dly = 3; pending[0] = 1; load_ops(0, 1'b0); drive_req();
        run_quiet(100);
        check_eq("start_hi_cycles", start_hi, 3);
        ready_dly = 1;

        // Done together with ready
        done_dly = 0; pending[1] = 1; load_ops(1, 1'b0); drive_req();
        run_quiet(100);
        done_dly = 4;

        // Output valid missing at done
        vld_mask = 3'b101; pending[2] = 1; load_ops(2, 1'b0); drive_req();
        run_quiet(100);
        vld_mask = 3'b111;

        // Watchdog timeout followed by drain
        never_done = 1'b1; pending[3] = 1; load_ops(3, 1'b0); drive_req();
        base = rsp_cnt;
        for (int i = 0; i < 100 && rsp_cnt == base; i++) step();
        check_eq("tmo_rsp_seen", rsp_cnt, base + 1);
        check_eq("tmo_latency", rsp_first_cyc - gnt_cyc, TMO);
        never_done = 1'b0;
        pending[0] = 1; load_ops(0, 1'b0); drive_req();
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("drain_busy", busy, 1);
            check_eq("drain_no_gnt", req_ready, '0);
        end
        drain_release = 1'b1;
        run_quiet(100);

        // Reset while the core is running
        done_dly = 30; pending[2] = 1; load_ops(2, 1'b0); drive_req();
        for (int i = 0; i < 50 && phase != 1; i++) step();
        step(); step();
        check_eq("wait_busy", busy, 1);
        pending[2] = 0; drive_req();
        ap_rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        ap_rst = 1'b0;
        exp_q.delete(); done_dly = 4;
        pending[0] = 1; pending[3] = 1; load_ops(0, 1'b0); load_ops(3, 1'b0); drive_req();
        gnt_log.delete();
        run_quiet(200);
        check_eq("post_rst_count", gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            check_eq("post_rst_first", gnt_log[0], 0);
            check_eq("post_rst_second", gnt_log[1], 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
